// File: rtl/fnd_scan_decoder.sv
// Passive receiver for the multiplexed 4-digit FND scan bus: samples each scan slot,
// decodes active-low segment/dp codes and publishes one coherent frame per complete scan.
module fnd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digits,
    output logic [3:0]  dots,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        active
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYCLES);

    function automatic logic [3:0] seg_to_bcd(input logic [7:0] code);
        case (code)
            8'hc0:   return 4'd0;
            8'hf9:   return 4'd1;
            8'ha4:   return 4'd2;
            8'hb0:   return 4'd3;
            8'h99:   return 4'd4;
            8'h92:   return 4'd5;
            8'h82:   return 4'd6;
            8'hf8:   return 4'd7;
            8'h80:   return 4'd8;
            8'h90:   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    logic [3:0]       com_s1_q, com_s2_q, com_prev_q;
    logic [7:0]       data_s1_q, data_s2_q, data_prev_q;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic             sampled_q, sampled_d;
    logic [15:0]      sh_digits_q, sh_digits_d;
    logic [3:0]       sh_dots_q, sh_dots_d;
    logic [3:0]       seen_d_q, seen_d_d;
    logic [3:0]       seen_p_q, seen_p_d;
    logic             err_q, err_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dots_q, dots_d;
    logic             fv_q, fv_d;
    logic             ferr_q, ferr_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic       com_chg, any_chg, in_visit, fire, boundary;
    logic [1:0] pos;
    logic [3:0] dec;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        in_visit = 1'b0;
        pos      = 2'd0;
        case (com_s2_q)
            4'b1110: begin in_visit = 1'b1; pos = 2'd0; end
            4'b1101: begin in_visit = 1'b1; pos = 2'd1; end
            4'b1011: begin in_visit = 1'b1; pos = 2'd2; end
            4'b0111: begin in_visit = 1'b1; pos = 2'd3; end
            default: begin in_visit = 1'b0; pos = 2'd0; end
        endcase

        com_chg  = (com_s2_q != com_prev_q);
        any_chg  = com_chg || (data_s2_q != data_prev_q);
        boundary = (com_prev_q == 4'b0111) && (com_s2_q == 4'b1110);
        dec      = seg_to_bcd(data_s2_q);

        stab_d    = any_chg ? '0 : ((stab_q == SETTLE_MAX) ? stab_q : stab_q + CNT_W'(1));
        fire      = in_visit && !sampled_q && !any_chg && (stab_q == SETTLE_LAST);
        // One sample per visit: the flag only re-arms when the common lines move.
        sampled_d = com_chg ? 1'b0 : (sampled_q || fire);

        sh_digits_d = sh_digits_q;
        sh_dots_d   = sh_dots_q;
        seen_d_d    = seen_d_q;
        seen_p_d    = seen_p_q;
        err_d       = err_q;
        if (fire) begin
            case (data_s2_q)
                8'h7f: begin sh_dots_d[pos] = 1'b1; seen_p_d[pos] = 1'b1; end
                8'hff: begin sh_dots_d[pos] = 1'b0; seen_p_d[pos] = 1'b1; end
                default: begin
                    sh_digits_d[{pos, 2'b00} +: 4] = dec;
                    seen_d_d[pos] = 1'b1;
                    if (dec == 4'hF) err_d = 1'b1;
                end
            endcase
        end

        digits_d = digits_q;
        dots_d   = dots_q;
        ferr_d   = ferr_q;
        fv_d     = 1'b0;
        to_d     = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
        // The boundary check sees any sample taken this cycle, then clears the frame state.
        if (boundary) begin
            if (&seen_d_d && &seen_p_d) begin
                digits_d = sh_digits_d;
                dots_d   = sh_dots_d;
                ferr_d   = err_d;
                fv_d     = 1'b1;
                to_d     = '0;
            end
            seen_d_d = '0;
            seen_p_d = '0;
            err_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            com_s1_q    <= 4'hF;
            com_s2_q    <= 4'hF;
            com_prev_q  <= 4'hF;
            data_s1_q   <= 8'hFF;
            data_s2_q   <= 8'hFF;
            data_prev_q <= 8'hFF;
            stab_q      <= '0;
            sampled_q   <= 1'b0;
            sh_digits_q <= 16'hFFFF;
            sh_dots_q   <= '0;
            seen_d_q    <= '0;
            seen_p_q    <= '0;
            err_q       <= 1'b0;
            digits_q    <= 16'hFFFF;
            dots_q      <= '0;
            fv_q        <= 1'b0;
            ferr_q      <= 1'b0;
            to_q        <= TO_MAX;
        end else begin
            com_s1_q    <= fnd_com;
            com_s2_q    <= com_s1_q;
            com_prev_q  <= com_s2_q;
            data_s1_q   <= fnd_data;
            data_s2_q   <= data_s1_q;
            data_prev_q <= data_s2_q;
            stab_q      <= stab_d;
            sampled_q   <= sampled_d;
            sh_digits_q <= sh_digits_d;
            sh_dots_q   <= sh_dots_d;
            seen_d_q    <= seen_d_d;
            seen_p_q    <= seen_p_d;
            err_q       <= err_d;
            digits_q    <= digits_d;
            dots_q      <= dots_d;
            fv_q        <= fv_d;
            ferr_q      <= ferr_d;
            to_q        <= to_d;
        end
    end

    assign digits      = digits_q;
    assign dots        = dots_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign active      = (to_q != TO_MAX);

endmodule
